// File: rtl/uart_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_arbiter
//  Description : Round-robin sharing of one UART command/response channel
//                among NUM_REQ requesters. Each transaction is granted,
//                issued as a single command, waits for UART completion and,
//                for reads, collects one returned byte or times out.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int CMD_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 100000,
  parameter int TO_W       = 17
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             resp_vld,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_err,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id,
  output logic [CMD_WIDTH-1:0]           uart_cmd,
  output logic                           uart_cmd_vld,
  input  logic                           uart_cmd_rdy,
  input  logic                           uart_read_rdy,
  input  logic [DATA_WIDTH-1:0]          uart_read_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(NUM_REQ - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_grant_id;
  logic [CMD_WIDTH-1:0]   r_uart_cmd;
  logic                   r_uart_cmd_vld;
  logic [NUM_REQ-1:0]     r_req_rdy;
  logic [NUM_REQ-1:0]     r_resp_vld;
  logic [DATA_WIDTH-1:0]  r_resp_data;
  logic                   r_resp_err;
  logic                   r_busy;
  logic                   r_is_read;
  logic                   r_got_resp;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_cmd_rdy_q;
  logic                   r_first_wait;

  logic                   w_found;
  logic [ID_W-1:0]        w_win;
  logic [ID_W-1:0]        w_cand;
  logic [CMD_WIDTH-1:0]   w_win_cmd;
  logic                   w_grant;
  logic                   w_in_wait;
  logic                   w_capture;
  logic                   w_rise;
  logic                   w_done_exit;
  logic                   w_resp_exit;
  logic                   w_timeout;

  // Round-robin search: first requesting index after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_vld[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_win_cmd   = req_cmd[w_win*CMD_WIDTH +: CMD_WIDTH];
  assign w_grant     = (r_state == S_IDLE) && w_found && uart_cmd_rdy;
  assign w_in_wait   = (r_state == S_WAIT_DONE) || (r_state == S_WAIT_RESP);
  // Only the first returned byte of a read is kept.
  assign w_capture   = w_in_wait && r_is_read && !r_got_resp && uart_read_rdy;
  // The first WAIT_DONE cycle is masked so a stale high level cannot count.
  assign w_rise      = uart_cmd_rdy && !r_cmd_rdy_q && !r_first_wait;
  assign w_done_exit = (r_state == S_WAIT_DONE) && w_rise;
  assign w_resp_exit = (r_state == S_WAIT_RESP) && uart_read_rdy;
  // A genuine exit on the terminal count takes precedence over the abort.
  assign w_timeout   = w_in_wait && !w_done_exit && !w_resp_exit &&
                       (r_to_cnt >= c_to_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Transaction sequencing: grant, issue, wait for completion, respond.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_next_state = S_ISSUE;
      S_ISSUE:     w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (w_done_exit) begin
          if (!r_is_read || r_got_resp || w_capture) w_next_state = S_RESP;
          else                                       w_next_state = S_WAIT_RESP;
        end else if (w_timeout) begin
          w_next_state = S_RESP;
        end
      end
      S_WAIT_RESP: if (w_resp_exit || w_timeout) w_next_state = S_RESP;
      S_RESP:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Datapath: grant bookkeeping, one-cycle pulses, capture and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= c_ptr_rst;
      r_grant_id     <= '0;
      r_uart_cmd     <= '0;
      r_uart_cmd_vld <= 1'b0;
      r_req_rdy      <= '0;
      r_resp_vld     <= '0;
      r_resp_data    <= '0;
      r_resp_err     <= 1'b0;
      r_busy         <= 1'b0;
      r_is_read      <= 1'b0;
      r_got_resp     <= 1'b0;
      r_to_cnt       <= '0;
      r_cmd_rdy_q    <= 1'b0;
      r_first_wait   <= 1'b0;
    end else begin
      r_req_rdy      <= '0;
      r_uart_cmd_vld <= 1'b0;
      r_resp_vld     <= '0;
      r_cmd_rdy_q    <= uart_cmd_rdy;
      r_first_wait   <= (r_state == S_ISSUE);
      r_busy         <= (w_next_state != S_IDLE);
      if (w_grant) begin
        r_uart_cmd     <= w_win_cmd;
        r_grant_id     <= w_win;
        r_ptr          <= w_win;
        r_req_rdy      <= NUM_REQ'(1) << w_win;
        r_uart_cmd_vld <= 1'b1;
        r_is_read      <= w_win_cmd[CMD_WIDTH-1];
        r_got_resp     <= 1'b0;
        r_resp_err     <= 1'b0;
        r_resp_data    <= '0;
        r_to_cnt       <= '0;
      end
      if (w_in_wait) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_capture) begin
        r_resp_data <= uart_read_data;
        r_got_resp  <= 1'b1;
      end
      if (w_timeout) begin
        r_resp_err  <= 1'b1;
        r_resp_data <= '0;
      end
      if ((w_next_state == S_RESP) && (r_state != S_RESP))
        r_resp_vld <= NUM_REQ'(1) << r_grant_id;
    end
  end

  assign req_rdy      = r_req_rdy;
  assign resp_vld     = r_resp_vld;
  assign resp_data    = r_resp_data;
  assign resp_err     = r_resp_err;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign uart_cmd     = r_uart_cmd;
  assign uart_cmd_vld = r_uart_cmd_vld;

endmodule
`default_nettype wire

// File: doc/uart_cmd_arbiter.md
Name: uart_cmd_arbiter

Overview:
- Shares one UART command/response channel among NUM_REQ requesters using round-robin arbitration.
- Sequences each transaction: grant, issue the 16-bit command, wait for UART completion, then (for reads, cmd[15]=1) collect the single returned byte or time out.
- Sits between the register-access clients and the UART block. Drives its cmd_in/cmd_vld, observes cmd_rdy, and consumes read_rdy/read_data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, grant index width, ceil(log2(NUM_REQ))
- CMD_WIDTH, 16, command width; bit CMD_WIDTH-1 = read flag
- DATA_WIDTH, 8, response data width
- TIMEOUT, 100000, max clk cycles spent in WAIT_DONE or WAIT_RESP before abort
- TO_W, 17, timeout counter width, must hold TIMEOUT

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester command valid (level, held until req_rdy)
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands, requester i at [i*CMD_WIDTH +: CMD_WIDTH]
- req_rdy  out  NUM_REQ  one-hot one-cycle accept pulse
- resp_vld  out  NUM_REQ  one-hot one-cycle completion pulse
- resp_data  out  DATA_WIDTH  read byte; valid with resp_vld
- resp_err  out  1  timeout flag; valid with resp_vld
- busy  out  1  high in any state except IDLE
- grant_id  out  ID_W  index of current or last granted requester
- uart_cmd  out  CMD_WIDTH  command to UART
- uart_cmd_vld  out  1  command valid to UART
- uart_cmd_rdy  in  1  UART idle/ready
- uart_read_rdy  in  1  one-cycle pulse, received byte valid and parity-checked
- uart_read_data  in  DATA_WIDTH  received byte

Behaviour:
- Reset (async, rst_n low): state=IDLE. req_rdy, resp_vld, uart_cmd_vld, resp_err, busy = 0. resp_data, uart_cmd, grant_id = 0. Round-robin pointer ptr = NUM_REQ-1, so requester 0 has first priority. All counters and flags = 0. Reset mid-transaction aborts with no resp_vld.
- States: IDLE, ISSUE, WAIT_DONE, WAIT_RESP, RESP.
- IDLE: when any req_vld bit is set and uart_cmd_rdy=1, select the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - On the next edge: latch that requester's cmd into uart_cmd; set grant_id and ptr to the winner; pulse req_rdy[winner] for exactly 1 cycle; latch is_read = cmd[CMD_WIDTH-1]; clear got_resp, resp_err and the timeout counter; go to ISSUE.
  - If uart_cmd_rdy=0, stay in IDLE with no grant.
- ISSUE: uart_cmd_vld=1 for exactly one cycle (uart_cmd stable), then go to WAIT_DONE.
- WAIT_DONE: exit on a rising edge of uart_cmd_rdy, detected against its registered previous value; the first cycle is ignored, so a high level left over from before issue does not count.
  - On exit, for a write (is_read=0) go to RESP.
  - On exit, for a read: go to RESP if got_resp=1, otherwise go to WAIT_RESP.
- Response capture: in WAIT_DONE and WAIT_RESP, uart_read_rdy=1 with is_read=1 captures uart_read_data into resp_data and sets got_resp.
  - Only the first pulse is captured.
  - Pulses in IDLE, ISSUE or RESP, or during writes, are dropped.
- WAIT_RESP: go to RESP on uart_read_rdy (capturing data that same edge).
- Timeout: the counter increments every cycle in WAIT_DONE/WAIT_RESP and persists across the two states.
  - When it reaches TIMEOUT-1 with no exit condition, set resp_err=1, force resp_data=0 and go to RESP.
  - If the exit condition and the terminal count coincide, the exit wins and resp_err=0.
- RESP: resp_vld[grant_id]=1 for one cycle with resp_data/resp_err, then go to IDLE.
  - Writes return resp_data=0, resp_err=0.
  - At least one idle cycle separates transactions, since arbitration is only evaluated in IDLE.
- A requester dropping req_vld before grant is legal and simply loses arbitration. A requester may re-request immediately after its resp_vld; it gets lowest priority next round.
- busy = (state != IDLE), registered.

Test Plan:
- Single write: req_vld=4'b0001, cmd 16'h1234 -> req_rdy[0] pulse; uart_cmd=16'h1234 with a 1-cycle uart_cmd_vld. After uart_cmd_rdy goes low then high -> resp_vld[0] pulse, resp_err=0, resp_data=0.
- Single read: requester 2, cmd 16'h8A00; UART model returns uart_read_rdy with data 8'h5C before cmd_rdy rises -> resp_vld[2] with resp_data=8'h5C, resp_err=0. Repeat with the byte arriving 50 cycles after cmd_rdy rises: same result.
- Round robin: all four req_vld held high with writes -> grant order 0,1,2,3,0. After reset, the first grant is 0. Hold only 1 and 3 high -> alternates 1,3,1.
- Read timeout: TIMEOUT=200, read cmd 16'hFF01, no uart_read_rdy -> resp_vld pulses exactly 200 cycles after entering WAIT_DONE, with resp_err=1 and resp_data=0. The next request is then served normally.
- UART not ready: uart_cmd_rdy=0 held while req_vld=4'b1000 -> no req_rdy and busy=0. Release it -> grant to 3 on the next edge.
- Reset mid-read in WAIT_RESP -> all outputs return to reset values immediately; no resp_vld, ptr resets, and a stray uart_read_rdy after reset is ignored.
